oled_pixel_streamer: RTL and testbench

Frame scanner and SPI transmitter for the 96x64 RGB565 OLED. Walks the pixel index, presents x/y coordinates to the pixel-colour generators, captures each returned 16-bit colour word, and shifts it MSB-first to the panel, optionally preceded by a column/row window command sequence. It sits between the colour-generating task blocks and the OLED pins, in the 6.25 MHz clock domain.

---
 rtl/oled_pixel_streamer_if.sv | 25 ++
 rtl/oled_pixel_streamer.sv | 206 ++++++++++++++++++++
 tb/tb_oled_pixel_streamer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/oled_pixel_streamer_if.sv
// Pixel-source and OLED pin bundle for oled_pixel_streamer.
// master = streamer side, slave = colour generator / panel / controller side.
interface oled_pixel_streamer_if;
  logic        frame_en;
  logic [15:0] pixel_data;
  logic [12:0] pixel_index;
  logic [6:0]  x;
  logic [5:0]  y;
  logic        cs_n;
  logic        sclk;
  logic        sdin;
  logic        dc;
  logic        frame_begin;
  logic        busy;

  modport master (
    input  frame_en, pixel_data,
    output pixel_index, x, y, cs_n, sclk, sdin, dc, frame_begin, busy
  );

  modport slave (
    output frame_en, pixel_data,
    input  pixel_index, x, y, cs_n, sclk, sdin, dc, frame_begin, busy
  );
endinterface

// File: rtl/oled_pixel_streamer.sv
// Frame scanner and MSB-first SPI shifter for an RGB565 OLED (96x64 by default).
// Define OLED_WINDOW_CMD_EN to prefix every frame with the column/row window command bytes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | cs_n high, waiting for frame_en
// CMD      | 6 window command bytes, dc=0, 16 cycles per byte
// PREFETCH | 4 cycles at pixel 0, first colour word captured on the last
// PIXEL    | 32-cycle slots, 16 bits each, coordinates one pixel ahead
// GAP      | cs_n high for GAP_CYCLES, then restart or go idle
module oled_pixel_streamer #(
  parameter int WIDTH      = 96,
  parameter int HEIGHT     = 64,
  parameter int GAP_CYCLES = 16
) (
  input logic                   CLK,
  input logic                   RESET_N,
  oled_pixel_streamer_if.master bus
);

  localparam int NPIX     = WIDTH * HEIGHT;
  localparam int CMD_LEN  = 96;
  localparam int PRE_LEN  = 4;
  localparam int SLOT_LEN = 32;
  localparam int CNT_MAX  = (GAP_CYCLES > CMD_LEN) ? GAP_CYCLES : CMD_LEN;
  localparam int CW       = $clog2(CNT_MAX);

  localparam logic [CW-1:0] PRE_LOAD  = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] SLOT_LOAD = CW'(SLOT_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [6:0]    X_LAST    = 7'(WIDTH - 1);
  localparam logic [5:0]    Y_LAST    = 6'(HEIGHT - 1);
  localparam logic [12:0]   IDX_LAST  = 13'(NPIX - 1);

  typedef enum logic [2:0] {IDLE, CMD, PREFETCH, PIXEL, GAP} state_t;

`ifdef OLED_WINDOW_CMD_EN
  localparam logic [CW-1:0] CMD_LOAD    = CW'(CMD_LEN - 1);
  localparam state_t        START_STATE = CMD;
  localparam logic [CW-1:0] START_LOAD  = CMD_LOAD;
`else
  localparam state_t        START_STATE = PREFETCH;
  localparam logic [CW-1:0] START_LOAD  = PRE_LOAD;
`endif

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [6:0]    x_q;
  logic [5:0]    y_q;
  logic [12:0]   idx_q;
  logic [15:0]   word_q;
  logic          load_word, advance;
  logic          cs_n_c, sclk_c, sdin_c, dc_c, busy_c;

  // Coordinates already point at the pixel after the one being sent, so
  // index 0 inside PIXEL can only mean the final slot of the frame.
  logic last_slot;
  assign last_slot = (idx_q == '0);

`ifdef OLED_WINDOW_CMD_EN
  logic [2:0] cmd_sel;
  logic [7:0] cmd_cur;
  always_comb begin
    cmd_sel = 3'd5 - cnt[6:4];
    case (cmd_sel)
      3'd0:    cmd_cur = 8'h15;
      3'd1:    cmd_cur = 8'h00;
      3'd2:    cmd_cur = 8'(WIDTH - 1);
      3'd3:    cmd_cur = 8'h75;
      3'd4:    cmd_cur = 8'h00;
      default: cmd_cur = 8'(HEIGHT - 1);
    endcase
  end
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt - 1'b1;
    load_word = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (bus.frame_en) begin
          state_d = START_STATE;
          cnt_d   = START_LOAD;
        end
      end
`ifdef OLED_WINDOW_CMD_EN
      CMD: begin
        if (cnt == '0) begin
          state_d = PREFETCH;
          cnt_d   = PRE_LOAD;
        end
      end
`endif
      PREFETCH: begin
        if (cnt == '0) begin
          state_d   = PIXEL;
          cnt_d     = SLOT_LOAD;
          load_word = 1'b1;
          advance   = 1'b1;
        end
      end
      PIXEL: begin
        if (cnt == '0) begin
          if (last_slot) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d     = SLOT_LOAD;
            load_word = 1'b1;
            advance   = 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (bus.frame_en) begin
            state_d = START_STATE;
            cnt_d   = START_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Odd counter values are the sclk-low half of each bit cell, so sdin only
  // moves while sclk is low and the panel sees it settled on the rising edge.
  always_comb begin
    cs_n_c = 1'b1;
    sclk_c = 1'b1;
    sdin_c = 1'b0;
    dc_c   = 1'b0;
    busy_c = 1'b1;
    case (state)
      IDLE: busy_c = 1'b0;
`ifdef OLED_WINDOW_CMD_EN
      CMD: begin
        cs_n_c = 1'b0;
        sclk_c = ~cnt[0];
        sdin_c = cmd_cur[cnt[3:1]];
      end
`endif
      PREFETCH: begin
        cs_n_c = 1'b0;
        dc_c   = 1'b1;
      end
      PIXEL: begin
        cs_n_c = 1'b0;
        dc_c   = 1'b1;
        sclk_c = ~cnt[0];
        sdin_c = word_q[cnt[4:1]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_q    <= '0;
      y_q    <= '0;
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      if (load_word) word_q <= bus.pixel_data;
      if (advance) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign bus.cs_n        = cs_n_c;
  assign bus.sclk        = sclk_c;
  assign bus.sdin        = sdin_c;
  assign bus.dc          = dc_c;
  assign bus.busy        = busy_c;
  assign bus.frame_begin = (state == START_STATE) && (cnt == START_LOAD);
  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.pixel_index = idx_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Scoreboard bench for oled_pixel_streamer: a 96x3 panel keeps whole frames short
// while still exercising the 95 -> (0,1) column wrap and the final-pixel wrap.
module tb_oled_pixel_streamer;
  localparam int W    = 96;
  localparam int H    = 3;
  localparam int GAP  = 16;
  localparam int NPIX = W * H;
`ifdef OLED_WINDOW_CMD_EN
  localparam int CMD_LEN   = 96;
  localparam int CMD_BYTES = 6;
`else
  localparam int CMD_LEN   = 0;
  localparam int CMD_BYTES = 0;
`endif
  // frame_begin to frame_begin with frame_en held: command, prefetch, slots, gap
  localparam int PERIOD = CMD_LEN + 4 + NPIX * 32 + GAP;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   src_const = 1'b1;
  bit   aborting = 1'b0;
  logic [16:0] exp_q[$];

  oled_pixel_streamer_if bus();

  oled_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .GAP_CYCLES(GAP)) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // colour source with one cycle of registered latency
  always @(posedge CLK) bus.pixel_data <= src_const ? 16'hF800 : {3'b000, bus.y, bus.x};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input bit konst);
`ifdef OLED_WINDOW_CMD_EN
    logic [7:0] cmds [6];
    cmds = '{8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h02};
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, 8'h00, cmds[i]});
`endif
    for (int k = 0; k < NPIX; k++) begin
      if (konst) exp_q.push_back({1'b1, 16'hF800});
      else       exp_q.push_back({1'b1, 3'b000, 6'(k / W), 7'(k % W)});
    end
  endtask

  task automatic wait_fb(input int limit, output int at);
    int k;
    k = 0;
    while (bus.frame_begin !== 1'b1 && k < limit) begin
      @(negedge CLK);
      k++;
    end
    chk("frame_begin_seen", bus.frame_begin, 1'b1);
    at = cyc;
  endtask

  task automatic wait_cs_rise(input int limit);
    int k;
    k = 0;
    while (bus.cs_n !== 1'b1 && k < limit) begin
      @(negedge CLK);
      k++;
    end
    chk("cs_n_rise_seen", bus.cs_n, 1'b1);
  endtask

  // monitor: rebuild words from sdin on sclk rising edges, pop and compare
  logic        sclk_prev = 1'b1;
  logic        cs_prev = 1'b1;
  logic        wdc = 1'b0;
  logic [15:0] wacc = '0;
  int          nbits = 0;
  int          npix = 0;
  int          ncmd = 0;

  always @(negedge CLK) begin
    logic [16:0] e;
    if (bus.cs_n === 1'b0 && sclk_prev === 1'b0 && bus.sclk === 1'b1) begin
      if (nbits == 0) wdc = bus.dc;
      wacc = {wacc[14:0], bus.sdin};
      nbits++;
      if (nbits == (wdc ? 16 : 8)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got dc=%0b data=%04h, expected no word", wdc, wacc);
        end else begin
          e = exp_q.pop_front();
          chk(wdc ? "pixel_word" : "cmd_byte", {15'b0, wdc, wacc}, {15'b0, e});
        end
        if (wdc) npix++;
        else     ncmd++;
        nbits = 0;
        wacc  = '0;
      end
    end
    if (cs_prev === 1'b0 && bus.cs_n === 1'b1) begin
      if (!aborting) begin
        chk("pixel_words_per_frame", npix, NPIX);
        chk("cmd_bytes_per_frame", ncmd, CMD_BYTES);
        chk("partial_bits_at_cs_rise", nbits, 0);
      end
      npix  = 0;
      ncmd  = 0;
      nbits = 0;
      wacc  = '0;
    end
    sclk_prev = bus.sclk;
    cs_prev   = bus.cs_n;
  end

  initial begin
    int t_a, t_b, k, nfb, nlow;
    bus.frame_en = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_pins", {bus.cs_n, bus.sclk, bus.sdin, bus.dc, bus.frame_begin, bus.busy}, 6'b110000);
    chk("reset_coords", {bus.pixel_index, bus.x, bus.y}, 0);

    // frame A: constant red, released from reset with frame_en high
    push_frame(1'b1);
    bus.frame_en = 1'b1;
    RESET_N = 1'b1;
    wait_fb(20, t_a);
    chk("fb_cs_n_low", bus.cs_n, 1'b0);
    chk("fb_busy", bus.busy, 1'b1);
    k = 0;
    while (!(bus.cs_n === 1'b0 && bus.dc === 1'b1 && bus.sclk === 1'b0) && k < 300) begin
      @(negedge CLK);
      k++;
    end
    chk("first_pixel_bit_delay", k, CMD_LEN + 4);
    wait_cs_rise(PERIOD + 100);

    // frame B: coordinate echo, back-to-back
    src_const = 1'b0;
    push_frame(1'b0);
    k = 0;
    while (bus.cs_n === 1'b1 && k < 100) begin
      k++;
      @(negedge CLK);
    end
    chk("gap_cs_high_cycles", k, GAP);
    chk("fb_after_gap", bus.frame_begin, 1'b1);
    t_b = cyc;
    chk("frame_period", t_b - t_a, PERIOD);

    repeat (2000) @(negedge CLK);
    bus.frame_en = 1'b0;
    wait_cs_rise(PERIOD + 100);
    k = 0;
    while (bus.busy === 1'b1 && k < 100) begin
      k++;
      @(negedge CLK);
    end
    chk("busy_through_gap", k, GAP);
    nfb = 0;
    nlow = 0;
    repeat (100) begin
      if (bus.frame_begin === 1'b1) nfb++;
      if (bus.cs_n !== 1'b1) nlow++;
      @(negedge CLK);
    end
    chk("no_restart_fb", nfb, 0);
    chk("no_restart_cs", nlow, 0);
    chk("idle_busy", bus.busy, 1'b0);

    // frame C: aborted by reset mid-pixel
    push_frame(1'b0);
    bus.frame_en = 1'b1;
    wait_fb(20, t_a);
    repeat (500) @(negedge CLK);
    chk("pre_reset_busy", bus.busy, 1'b1);
    aborting = 1'b1;
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    chk("reset_mid_pins", {bus.cs_n, bus.sclk, bus.busy, bus.frame_begin}, 4'b1100);
    chk("reset_mid_coords", {bus.pixel_index, bus.x, bus.y}, 0);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    exp_q.delete();
    aborting = 1'b0;

    // frame D: clean frame after reset release
    push_frame(1'b0);
    @(posedge CLK);
    #1 RESET_N = 1'b1;
    wait_fb(20, t_a);
    bus.frame_en = 1'b0;
    wait_cs_rise(PERIOD + 100);
    repeat (GAP + 4) @(negedge CLK);
    chk("final_idle_pins", {bus.busy, bus.cs_n, bus.sclk}, 3'b011);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
